qsram_refresh_array: RTL and testbench
======================================

Name: qsram_refresh_array

Overview:
- Parametrised, clocked quasi-static RAM array built from refreshable storage rows. Each row loses its contents if it is not restored within a retention window.
- An internal round-robin refresh controller restores rows periodically and arbitrates against user read/write requests through a valid/ready handshake.
- Sits between the memory request path and the storage; replaces hand-wired single cells with a scalable array.

Parameters:
- DataWidth, 8, bits per word.
- Depth, 16, number of rows (any value ≥2).
- AddrWidth, 4, address width; must satisfy 2**AddrWidth ≥ Depth.
- RefreshInterval, 8, cycles between automatic refresh operations (≥2).
- RetentionCycles, 200, cycles a row holds data without a restore (≥2).

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- RefreshEnable  input  1  enables the automatic refresh timer.
- ReqValid  input  1  request present.
- ReqReady  output  1  request accepted this cycle when high with ReqValid.
- ReqWrite  input  1  1 = write, 0 = read.
- ReqAddress  input  AddrWidth  row address.
- ReqData  input  DataWidth  write data.
- RespValid  output  1  read response valid (1-cycle pulse).
- RespData  output  DataWidth  read data.
- RespDecayed  output  1  read row had decayed or address out of range.
- RefreshBusy  output  1  internal refresh occurring this cycle.

Behaviour:
- Reset (sync, Clock edge with Reset=1):
  - All rows: data=0, alive=0, age=0.
  - Refresh pointer=0, interval counter=0.
  - RespValid=0, RespData=0, RespDecayed=0.
  - Reset overrides any in-flight request; no response is produced for a request presented in the reset cycle.
- Per-row state: data, alive bit, age counter (saturating at RetentionCycles-1).
  - Each edge, a row that is not restored has its age incremented.
  - If a non-restored row has age == RetentionCycles-1 at the edge: alive←0, data←0 (decay).
  - A row written at edge t is readable with correct data by reads accepted at edges t+1 .. t+RetentionCycles-1 when it is never restored.
- Restore: age←0. Applies only if alive=1; a restore never revives a decayed row.
  - Restore sources: a write (which also sets alive←1 and data←ReqData), an accepted read of an alive row, or a refresh.
  - Restore beats increment/decay on the same edge. A write beats decay.
- Refresh timer:
  - refresh_due (combinational) = RefreshEnable & (counter == RefreshInterval-1).
  - Counter increments each edge while RefreshEnable=1, wraps to 0 on refresh_due, and holds while RefreshEnable=0.
  - On refresh_due: restore row[pointer]; pointer increments, wrapping Depth-1→0.
  - RefreshBusy = refresh_due.
- Arbitration:
  - ReqReady = ~refresh_due (combinational); refresh has absolute priority.
  - A request is accepted on an edge where ReqValid & ReqReady.
  - A request held with ReqValid=1 during a refresh cycle is accepted on the next ready cycle.
  - Inputs must stay stable until accepted.
- Write accepted: data←ReqData, alive←1, age←0. No response. If ReqAddress ≥ Depth, the write is ignored.
- Read accepted at edge t:
  - At t, RespValid←1, RespData←(alive ? data : 0), RespDecayed←~alive; the values are visible in the cycle after t.
  - Otherwise RespValid←0 and RespData/RespDecayed hold.
  - Address ≥ Depth: RespData=0, RespDecayed=1.
  - Back-to-back reads yield back-to-back responses.
  - A read uses the row state before the same edge's decay evaluation; a row that decays at t returns valid data.
- Write and refresh never share a cycle, because ReqReady is low during refresh.

Test Plan (DataWidth=8, Depth=4, RefreshInterval=4, RetentionCycles=20):
- Reset, then read addr 2 → RespValid=1 one cycle later, RespData=0x00, RespDecayed=1; ReqReady=1 except every 4th cycle with RefreshEnable=1.
- RefreshEnable=1; write 0xA5 to addr 1, idle 200 cycles, read addr 1 → 0xA5, RespDecayed=0 (each row refreshed every 16 cycles, which is under 20).
- RefreshEnable=0; write 0x3C to addr 0 at edge t.
  - Read accepted at t+19 → 0x3C.
  - Repeat with the read accepted at t+20 → 0x00, RespDecayed=1.
  - Write again → readable again.
- RefreshEnable=0; write 0x11 at t, read addr 0 every 10 cycles for 100 cycles → all return 0x11 (reads restore).
- ReqValid held high with a write on a refresh_due cycle → ReqReady=0, RefreshBusy=1, write lands the following edge; pointer sequence observed 0,1,2,3,0.
- Assert Reset mid-stream with a read pending → the next cycle shows RespValid=0, all rows decayed, and the first refresh occurs 4 cycles after reset release.

Source files
------------

// File: rtl/qsram_refresh_array.sv
// Quasi-static RAM array of refreshable rows: each row decays unless restored within
// its retention window, and a round-robin refresh engine competes with user requests.
module qsram_refresh_array #(
  parameter int DataWidth       = 8,
  parameter int Depth           = 16,
  parameter int AddrWidth       = 4,
  parameter int RefreshInterval = 8,
  parameter int RetentionCycles = 200
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_refreshEnable,
  input  logic                 i_reqValid,
  output logic                 o_reqReady,
  input  logic                 i_reqWrite,
  input  logic [AddrWidth-1:0] i_reqAddress,
  input  logic [DataWidth-1:0] i_reqData,
  output logic                 o_respValid,
  output logic [DataWidth-1:0] o_respData,
  output logic                 o_respDecayed,
  output logic                 o_refreshBusy
);

  localparam int AgeWidth   = $clog2(RetentionCycles);
  localparam int CountWidth = $clog2(RefreshInterval);
  localparam int PtrWidth   = $clog2(Depth);

  // A row whose age already equals AgeLast reaches the saturation value on this edge and decays.
  localparam logic [AgeWidth-1:0]   AgeLast   = AgeWidth'(RetentionCycles - 2);
  localparam logic [AgeWidth-1:0]   AgeMax    = AgeWidth'(RetentionCycles - 1);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(RefreshInterval - 1);
  localparam logic [PtrWidth-1:0]   PtrLast   = PtrWidth'(Depth - 1);

  logic [DataWidth-1:0]  r_data [Depth];
  logic [AgeWidth-1:0]   r_age  [Depth];
  logic [Depth-1:0]      r_alive;
  logic [CountWidth-1:0] r_refreshCount;
  logic [PtrWidth-1:0]   r_refreshPtr;
  logic                  r_respValid;
  logic [DataWidth-1:0]  r_respData;
  logic                  r_respDecayed;

  logic                  w_refreshDue;
  logic                  w_accept;
  logic                  w_readAlive;
  logic [DataWidth-1:0]  w_readData;
  logic [Depth-1:0]      w_addrHit;
  logic [Depth-1:0]      w_writeHit;
  logic [Depth-1:0]      w_restoreHit;

  assign w_refreshDue  = i_refreshEnable & (r_refreshCount == CountLast);
  assign w_accept      = i_reqValid & ~w_refreshDue;
  assign o_reqReady    = ~w_refreshDue;
  assign o_refreshBusy = w_refreshDue;
  assign o_respValid   = r_respValid;
  assign o_respData    = r_respData;
  assign o_respDecayed = r_respDecayed;

  // Out-of-range addresses match no row, so they read back as decayed zero and writes vanish.
  always_comb begin
    w_addrHit    = '0;
    w_writeHit   = '0;
    w_restoreHit = '0;
    w_readData   = '0;
    w_readAlive  = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      w_addrHit[i]    = (i_reqAddress == AddrWidth'(i));
      w_writeHit[i]   = w_accept & i_reqWrite & w_addrHit[i];
      w_restoreHit[i] = (w_accept & ~i_reqWrite & w_addrHit[i]) |
                        (w_refreshDue & (r_refreshPtr == PtrWidth'(i)));
      if (w_addrHit[i]) begin
        w_readData  = r_data[i];
        w_readAlive = r_alive[i];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_refreshCount <= '0;
      r_refreshPtr   <= '0;
    end else if (i_refreshEnable) begin
      if (w_refreshDue) begin
        r_refreshCount <= '0;
        r_refreshPtr   <= (r_refreshPtr == PtrLast) ? '0 : r_refreshPtr + 1'b1;
      end else begin
        r_refreshCount <= r_refreshCount + 1'b1;
      end
    end
  end

  // Priority per row: write, then restore of a live row, then decay, then ageing.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_data[i]  <= '0;
        r_age[i]   <= '0;
        r_alive[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (w_writeHit[i]) begin
          r_data[i]  <= i_reqData;
          r_alive[i] <= 1'b1;
          r_age[i]   <= '0;
        end else if (w_restoreHit[i] && r_alive[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] >= AgeLast) begin
          r_data[i]  <= '0;
          r_alive[i] <= 1'b0;
          r_age[i]   <= AgeMax;
        end else begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_respValid   <= 1'b0;
      r_respData    <= '0;
      r_respDecayed <= 1'b0;
    end else if (w_accept && !i_reqWrite) begin
      r_respValid   <= 1'b1;
      r_respData    <= w_readAlive ? w_readData : '0;
      r_respDecayed <= ~w_readAlive;
    end else begin
      r_respValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qsram_refresh_array.sv
// Randomized and directed bench for qsram_refresh_array; a time-stamp reference model
// predicts responses into a queue that a negedge monitor drains.
module tb_qsram_refresh_array;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int RI    = 4;
  localparam int RET   = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          refreshEnable = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqWrite = 1'b0;
  logic [AW-1:0] reqAddress = '0;
  logic [DW-1:0] reqData = '0;
  logic          reqReady;
  logic          respValid;
  logic [DW-1:0] respData;
  logic          respDecayed;
  logic          refreshBusy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          decayed;
  } resp_t;

  resp_t expQ[$];

  // Model: a row is alive while it was written and has been restored within RET-1 edges.
  logic [DW-1:0] mData [DEPTH];
  bit            mValid [DEPTH];
  longint        mLast [DEPTH];
  longint        edgeNum = 0;
  int            enCount = 0;
  int            refCount = 0;
  bit            started = 0;

  qsram_refresh_array #(
    .DataWidth(DW), .Depth(DEPTH), .AddrWidth(AW),
    .RefreshInterval(RI), .RetentionCycles(RET)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_refreshEnable(refreshEnable),
    .i_reqValid(reqValid),
    .o_reqReady(reqReady),
    .i_reqWrite(reqWrite),
    .i_reqAddress(reqAddress),
    .i_reqData(reqData),
    .o_respValid(respValid),
    .o_respData(respData),
    .o_respDecayed(respDecayed),
    .o_refreshBusy(refreshBusy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model, evaluated on every rising edge from the inputs held stable since the last edge.
  initial begin
    forever begin
      @(posedge clock);
      edgeNum++;
      if (reset) begin
        started = 1;
        expQ.delete();
        enCount = 0;
        refCount = 0;
        for (int r = 0; r < DEPTH; r++) begin
          mValid[r] = 0;
          mData[r] = '0;
          mLast[r] = 0;
        end
      end else begin
        bit due;
        bit accept;
        bit inRange;
        due = refreshEnable && ((enCount % RI) == RI - 1);
        accept = reqValid && !due;
        inRange = (int'(reqAddress) < DEPTH);
        for (int r = 0; r < DEPTH; r++) begin
          if (mValid[r] && (edgeNum - mLast[r]) > RET - 1) begin
            mValid[r] = 0;
            mData[r] = '0;
          end
        end
        if (due) begin
          if (mValid[refCount % DEPTH]) mLast[refCount % DEPTH] = edgeNum;
          refCount++;
        end
        if (accept && reqWrite && inRange) begin
          mValid[reqAddress] = 1;
          mData[reqAddress] = reqData;
          mLast[reqAddress] = edgeNum;
        end
        if (accept && !reqWrite) begin
          resp_t e;
          if (inRange && mValid[reqAddress]) begin
            e.data = mData[reqAddress];
            e.decayed = 1'b0;
            mLast[reqAddress] = edgeNum;
          end else begin
            e.data = '0;
            e.decayed = 1'b1;
          end
          expQ.push_back(e);
        end
        if (refreshEnable) enCount++;
      end
    end
  end

  // Monitor: arbitration outputs every cycle, and a response exactly when the scoreboard expects one.
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        bit expDue;
        expDue = refreshEnable && ((enCount % RI) == RI - 1);
        checkOutput("reqReady", {31'd0, reqReady}, {31'd0, !expDue});
        checkOutput("refreshBusy", {31'd0, refreshBusy}, {31'd0, expDue});
        if (respValid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", {31'd0, respValid}, 32'd0);
          end else begin
            resp_t e;
            e = expQ.pop_front();
            checkOutput("respData", {24'd0, respData}, {24'd0, e.data});
            checkOutput("respDecayed", {31'd0, respDecayed}, {31'd0, e.decayed});
          end
        end else if (expQ.size() != 0) begin
          checkOutput("missing_resp", {31'd0, respValid}, 32'd1);
          expQ.delete();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Holds the request until a rising edge sees it with ready high; returns the refused cycles.
  task automatic applyStimulus(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               output int waits);
    bit accepted;
    bit rdy;
    accepted = 0;
    waits = 0;
    reqValid = 1'b1;
    reqWrite = write;
    reqAddress = addr;
    reqData = data;
    for (int n = 0; n < 16 && !accepted; n++) begin
      @(negedge clock);
      rdy = reqReady;
      @(posedge clock);
      #1;
      accepted = rdy;
      if (!rdy) waits++;
    end
    reqValid = 1'b0;
    checkOutput("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic writeRow(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w;
    applyStimulus(1'b1, addr, data, w);
  endtask

  task automatic readExpect(input string name, input logic [AW-1:0] addr,
                            input logic [DW-1:0] expData, input bit expDecayed);
    int w;
    applyStimulus(1'b0, addr, '0, w);
    @(negedge clock);
    checkOutput({name, "_valid"}, {31'd0, respValid}, 32'd1);
    checkOutput({name, "_data"}, {24'd0, respData}, {24'd0, expData});
    checkOutput({name, "_decayed"}, {31'd0, respDecayed}, {31'd0, expDecayed});
    @(posedge clock);
    #1;
  endtask

  initial begin
    int waits;
    int found;
    $display("[TB] start");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    readExpect("reset_read", 3'd2, 8'h00, 1'b1);

    refreshEnable = 1'b1;
    writeRow(3'd1, 8'hA5);
    idle(200);
    readExpect("refreshed_row", 3'd1, 8'hA5, 1'b0);

    refreshEnable = 1'b0;
    writeRow(3'd0, 8'h3C);
    idle(18);
    readExpect("retention_last", 3'd0, 8'h3C, 1'b0);
    writeRow(3'd0, 8'h3C);
    idle(19);
    readExpect("retention_expired", 3'd0, 8'h00, 1'b1);
    writeRow(3'd0, 8'h3C);
    idle(1);
    readExpect("rewrite", 3'd0, 8'h3C, 1'b0);

    writeRow(3'd0, 8'h11);
    for (int k = 0; k < 10; k++) begin
      idle(9);
      readExpect("read_restores", 3'd0, 8'h11, 1'b0);
    end

    writeRow(3'd1, 8'h77);
    writeRow(3'd5, 8'hFF);
    readExpect("oob_read", 3'd5, 8'h00, 1'b1);
    readExpect("oob_no_alias", 3'd1, 8'h77, 1'b0);

    refreshEnable = 1'b1;
    for (int n = 0; n < RI + 1 && (enCount % RI) != RI - 1; n++) idle(1);
    applyStimulus(1'b1, 3'd2, 8'h5A, waits);
    checkOutput("held_write_waits", waits, 32'd1);
    readExpect("held_write_lands", 3'd2, 8'h5A, 1'b0);

    writeRow(3'd3, 8'hC3);
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddress = 3'd3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    reqValid = 1'b0;
    found = 0;
    for (int n = 1; n <= 8 && found == 0; n++) begin
      @(negedge clock);
      if (refreshBusy) found = n;
    end
    checkOutput("first_refresh_after_reset", found, RI);
    @(posedge clock);
    #1;
    for (int r = 0; r < DEPTH; r++) readExpect("post_reset_row", AW'(r), 8'h00, 1'b1);

    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 7) == 0) refreshEnable = ~refreshEnable;
      if ($urandom_range(0, 9) < 4) begin
        writeRow(AW'($urandom_range(0, 5)), DW'($urandom));
      end else begin
        applyStimulus(1'b0, AW'($urandom_range(0, 5)), '0, waits);
      end
      idle($urandom_range(0, 12));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
